// File: rtl/burst_vec_serdes.sv
// burst_vec_serdes: fetches data/weight bursts from two DMA read ports into LANES-wide
// operand vectors, then serialises the returned result vector back to a DMA write port.
module burst_vec_serdes #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_lanes,
  input  logic [31:0]             cfg_bursts,
  input  logic                    cfg_pad,
  input  logic [ADDR_W-1:0]       cfg_data_addr,
  input  logic [ADDR_W-1:0]       cfg_weight_addr,
  input  logic [ADDR_W-1:0]       cfg_result_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_d_en,
  output logic                    rd_w_en,
  output logic [ADDR_W-1:0]       rd_d_addr,
  output logic [ADDR_W-1:0]       rd_w_addr,
  input  logic                    rd_d_we,
  input  logic                    rd_w_we,
  input  logic [DATA_W-1:0]       rd_d_data,
  input  logic [DATA_W-1:0]       rd_w_data,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [LANES*DATA_W-1:0] vec_data,
  output logic [LANES*DATA_W-1:0] vec_weight,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [LANES*DATA_W-1:0] res_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  input  logic                    wr_re,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_valid
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, COLLECT, WRITE, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  lanes_q, d_cnt, w_cnt, wc;
  logic [CNT_W-1:0]  d_cnt_inc, w_cnt_inc, wc_inc;
  logic [31:0]       bursts_q, b_cnt;
  logic              pad_q;
  logic [DATA_W-1:0] d_buf [LANES];
  logic [DATA_W-1:0] w_buf [LANES];
  logic [DATA_W-1:0] r_buf [LANES];

  logic              start_ok, d_take, w_take, d_full, w_full;
  logic              wr_take, wr_last, last_burst;
  logic [ADDR_W-1:0] addr_step;

  function automatic logic [CNT_W-1:0] eff_lanes(input logic [CNT_W-1:0] req);
    if (req == '0 || req > CNT_W'(LANES)) return CNT_W'(LANES);
    return req;
  endfunction

  assign start_ok   = (state == IDLE) && start;
  assign d_cnt_inc  = d_cnt + CNT_W'(1);
  assign w_cnt_inc  = w_cnt + CNT_W'(1);
  assign wc_inc     = wc + CNT_W'(1);
  assign d_take     = (state == FETCH) && !pad_q && rd_d_we && (d_cnt < lanes_q);
  assign w_take     = (state == FETCH) && rd_w_we && (w_cnt < lanes_q);
  // Fill status counts a strobe taken this cycle so ISSUE follows the last strobe directly.
  assign d_full     = pad_q || (d_cnt == lanes_q) || (d_take && (d_cnt_inc == lanes_q));
  assign w_full     = (w_cnt == lanes_q) || (w_take && (w_cnt_inc == lanes_q));
  assign wr_take    = (state == WRITE) && wr_re && (wc < lanes_q);
  assign wr_last    = wr_take && (wc_inc == lanes_q);
  assign last_burst = ((b_cnt + 32'd1) == bursts_q);
  assign addr_step  = ADDR_W'(lanes_q);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_d_en   = (state == FETCH) && !pad_q && (d_cnt < lanes_q);
  assign rd_w_en   = (state == FETCH) && (w_cnt < lanes_q);
  assign vec_valid = (state == ISSUE);
  assign res_ready = (state == COLLECT);
  assign wr_en     = (state == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_bursts == 32'd0) ? DONE : FETCH;
      FETCH:   if (d_full && w_full) state_nxt = ISSUE;
      ISSUE:   if (vec_ready) state_nxt = COLLECT;
      COLLECT: if (res_valid) state_nxt = WRITE;
      WRITE:   if (wr_last) state_nxt = last_burst ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job configuration, counters and per-burst addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q   <= '0;
      bursts_q  <= '0;
      pad_q     <= 1'b0;
      b_cnt     <= '0;
      d_cnt     <= '0;
      w_cnt     <= '0;
      wc        <= '0;
      rd_d_addr <= '0;
      rd_w_addr <= '0;
      wr_addr   <= '0;
    end else begin
      if (start_ok) begin
        lanes_q   <= eff_lanes(cfg_lanes);
        bursts_q  <= cfg_bursts;
        pad_q     <= cfg_pad;
        rd_d_addr <= cfg_data_addr;
        rd_w_addr <= cfg_weight_addr;
        wr_addr   <= cfg_result_addr;
        b_cnt     <= '0;
        d_cnt     <= '0;
        w_cnt     <= '0;
        wc        <= '0;
      end
      if (d_take)  d_cnt <= d_cnt_inc;
      if (w_take)  w_cnt <= w_cnt_inc;
      if (wr_take) wc    <= wc_inc;
      if (wr_last) begin
        wc    <= '0;
        d_cnt <= '0;
        w_cnt <= '0;
        if (!last_burst) begin
          b_cnt     <= b_cnt + 32'd1;
          rd_d_addr <= rd_d_addr + addr_step;
          rd_w_addr <= rd_w_addr + addr_step;
          wr_addr   <= wr_addr + addr_step;
        end
      end
    end
  end

  // Lane buffers, result capture and write serialiser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        d_buf[i] <= '0;
        w_buf[i] <= '0;
        r_buf[i] <= '0;
      end
      wr_data  <= '0;
      wr_valid <= 1'b0;
    end else begin
      if (d_take) d_buf[d_cnt[IDX_W-1:0]] <= rd_d_data;
      if (w_take) w_buf[w_cnt[IDX_W-1:0]] <= rd_w_data;
      if (res_ready && res_valid) begin
        for (int i = 0; i < LANES; i++) r_buf[i] <= res_data[i*DATA_W +: DATA_W];
      end
      wr_valid <= wr_take;
      if (wr_take) wr_data <= r_buf[wc[IDX_W-1:0]];
    end
  end

  // Lanes beyond the active count, and all data lanes in pad mode, read as zero.
  always_comb begin
    vec_data   = '0;
    vec_weight = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < lanes_q) begin
        vec_weight[i*DATA_W +: DATA_W] = w_buf[i];
        if (!pad_q) vec_data[i*DATA_W +: DATA_W] = d_buf[i];
      end
    end
  end

endmodule

// File: doc/burst_vec_serdes.md
# burst_vec_serdes

Parametrised DMA-to-vector front end for the convolution/pooling datapath. It fetches bursts of data and weight elements from two DMA read ports and deserialises them into LANES-wide parallel vectors for the MAC/pool arrays. It then collects the returned result vector and serialises it to a DMA write port. Compared with the fixed 16×16-bit engine front end, it generalises element width and lane count, takes a runtime active-lane count and burst count, and adds a zero-padding mode and per-burst address stepping.

## Interface
- DATA_W, 16, element width in bits
- LANES, 16, parallel vector lanes
- ADDR_W, 30, DMA address width
- CNT_W, 8, width of lane config and counters
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high; one clock, all state on posedge clk
- start  in  1  one-cycle pulse that latches all cfg_* inputs; ignored unless idle
- cfg_lanes  in  CNT_W  active lanes per burst; 0 or >LANES is treated as LANES
- cfg_bursts  in  32  number of bursts to process
- cfg_pad  in  1  1 = data lanes zero-filled and the data port is not read
- cfg_data_addr, cfg_weight_addr, cfg_result_addr  in  ADDR_W  start addresses (element units)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- rd_d_en, rd_w_en  out  1  data/weight burst read request
- rd_d_addr, rd_w_addr  out  ADDR_W  burst start address
- rd_d_we, rd_w_we  in  1  element strobe from DMA
- rd_d_data, rd_w_data  in  DATA_W  element from DMA
- vec_valid  out  1  operand vector valid
- vec_ready  in  1  compute array accepts vector
- vec_data, vec_weight  out  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- res_valid  in  1  result vector valid
- res_ready  out  1  block accepts result
- res_data  in  LANES*DATA_W  result vector
- wr_en  out  1  burst write request
- wr_addr  out  ADDR_W  burst write start address
- wr_re  in  1  DMA pulls one element
- wr_data  out  DATA_W  element to DMA
- wr_valid  out  1  wr_data valid

## Operation
- FSM states: IDLE, FETCH, ISSUE, COLLECT, WRITE, DONE.
- IDLE -> FETCH on start when cfg_bursts != 0.
- IDLE -> DONE on start when cfg_bursts == 0.
- Burst counter b runs from 0 to cfg_bursts-1. Let L be the effective lane count.
- Burst addresses:
  - rd_d_addr = cfg_data_addr + b·L
  - rd_w_addr = cfg_weight_addr + b·L
  - wr_addr = cfg_result_addr + b·L
  - all modulo 2^ADDR_W.
- FETCH:
  - rd_w_en is held high until L weight strobes have been taken. rd_d_en behaves the same, except that it is never asserted when cfg_pad=1.
  - Each strobe writes element k into lane k and increments that port's counter.
  - Strobes arriving after a port's count reaches L are ignored.
  - Both ports fill independently. FETCH -> ISSUE when both counts equal L (the data count is taken as L in pad mode).
- Lane contents: lanes ≥ L are driven 0 on vec_data and vec_weight. In pad mode all data lanes are 0.
- ISSUE: vec_valid is high. The vector is held stable until vec_ready. On vec_valid & vec_ready, go to COLLECT.
- COLLECT: res_ready is high. On res_valid & res_ready, capture res_data and go to WRITE.
- WRITE:
  - wr_en is high. On each cycle with wr_re, drive wr_data = result lane wc on the next edge, set wr_valid=1, and increment wc. wr_valid=0 on cycles without wr_re.
  - After the L-th element, drop wr_en and clear wc.
  - Then go to FETCH with b+1, or to DONE when b+1 == cfg_bursts.
- DONE: pulse done for one cycle, then return to IDLE. busy falls with done.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters, lane buffers and the result buffer are 0.
- Assertion of rst at any point (mid-burst included) aborts immediately. No done is produced for the aborted job.
- Request assertion:
  - rd_*_en and rd_*_addr are registered and rise on the edge after start, or after the WRITE→FETCH transition.
  - The address is valid on the same cycle that the enable rises.
- Latencies:
  - Last fetch strobe -> vec_valid: 1 cycle.
  - vec handshake -> res_ready: 1 cycle.
  - Result capture -> wr_en: 1 cycle.
  - wr_re -> wr_valid/wr_data: 1 cycle.
- Simultaneous last data and last weight strobe: both are captured; ISSUE follows on the next cycle.
- start while busy is ignored, and cfg changes mid-job have no effect.
- Overflow: burst counter b is 32 bits; address arithmetic wraps modulo 2^ADDR_W.

## Test plan
- Defaults, cfg_lanes=16, cfg_bursts=1, data k=k+1, weights k=0x100+k:
  - vec_data lane k = k+1 and vec_weight lane k = 0x100+k.
  - Result echoed as 0x8000+k gives 16 wr_valid beats 0x8000..0x800F at wr_addr=cfg_result_addr.
  - One done pulse.
- cfg_lanes=5, cfg_bursts=3, data_addr=0x100:
  - rd_d_addr sequence 0x100, 0x105, 0x10A.
  - Lanes 5–15 = 0.
  - 5 write beats per burst; done after the third burst.
- cfg_pad=1, cfg_lanes=8:
  - rd_d_en never asserts.
  - vec_data all 0, vec_weight loaded.
  - Stray rd_d_we pulses are ignored.
- Backpressure: vec_ready held low for 10 cycles and wr_re toggled every other cycle:
  - vector stable throughout.
  - exactly cfg_lanes wr_valid beats in order.
  - an extra 17th weight strobe during FETCH is ignored.
- Boundaries:
  - cfg_bursts=0: done one cycle after start, no DMA activity.
  - cfg_lanes=0 or 20 behaves as 16.
  - data_addr=2^30−3 with 16 lanes: second burst address wraps to 13.
- rst asserted mid-WRITE (after 7 beats):
  - all outputs 0 immediately, no done.
  - a new start runs cleanly from burst 0.
